// File: rtl/runway_scheduler_pkg.sv
// Shared types for the runway scheduler: request encoding, FSM states, queued request word.
package BobATC;

  localparam int unsigned PLANE_ID_W = 4;
  localparam int unsigned RUNWAY_N   = 2;

  typedef enum logic {
    TAKEOFF = 1'b0,
    LANDING = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNLOCK = 2'd1,
    LOCK   = 2'd2,
    SETTLE = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [PLANE_ID_W-1:0] plane_id;
    req_type_t             req_type;
  } sched_req_t;

endpackage

// File: rtl/runway_scheduler_fifo.sv
// Synchronous FIFO holding pending requests of one type; head is visible without popping.
module sched_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_c, pop_c;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign rdata_c = mem_q[rd_ptr_q];
  assign push_c  = push && !full_c;
  assign pop_c   = pop && !empty_c;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the entry is not occupied
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/runway_scheduler.sv
// Runway scheduler: queues landing/takeoff requests, grants runways with landing priority
// and a takeoff starvation guard, and validates runway-clear reports before unlocking.
module runway_scheduler
  import BobATC::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_LAND_STREAK = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PLANE_ID_W-1:0] req_plane_id,
  input  logic                  req_type,
  input  logic                  done_valid,
  output logic                  done_ready,
  input  logic [PLANE_ID_W-1:0] done_plane_id,
  input  logic                  done_runway_id,
  input  logic [RUNWAY_N-1:0]   runway_active,
  output logic                  rw_lock,
  output logic                  rw_unlock,
  output logic [PLANE_ID_W-1:0] rw_plane_id,
  output logic                  rw_runway_id,
  output logic                  grant_valid,
  output logic [PLANE_ID_W-1:0] grant_plane_id,
  output logic                  grant_runway_id,
  output logic                  grant_type,
  output logic                  err_bad_done
);

  localparam int unsigned REQ_W    = $bits(sched_req_t);
  localparam int unsigned STREAK_W = $clog2(MAX_LAND_STREAK + 1);

  sched_state_t          state_q, state_d;
  logic                  rw_lock_q, rw_lock_d;
  logic                  rw_unlock_q, rw_unlock_d;
  logic [PLANE_ID_W-1:0] rw_plane_q, rw_plane_d;
  logic                  rw_runway_q, rw_runway_d;
  req_type_t             grant_type_q, grant_type_d;
  logic                  err_bad_done_q, err_bad_done_d;
  logic                  done_full_q, done_full_d;
  logic [PLANE_ID_W-1:0] done_plane_q, done_plane_d;
  logic                  done_runway_q, done_runway_d;
  logic [RUNWAY_N-1:0]   owner_vld_q, owner_vld_d;
  logic [PLANE_ID_W-1:0] owner_id_q [RUNWAY_N];
  logic [PLANE_ID_W-1:0] owner_id_d [RUNWAY_N];
  logic [STREAK_W-1:0]   streak_q, streak_d;

  sched_req_t req_word_c, land_head_c, take_head_c;
  logic       land_empty_c, land_full_c, take_empty_c, take_full_c;
  logic       push_land_c, push_take_c, pop_land_c, pop_take_c;
  logic       done_acc_c, done_ok_c, any_free_c, free_idx_c, pick_land_c;

  assign req_ready   = req_type ? !land_full_c : !take_full_c;
  assign done_ready  = !done_full_q;
  assign req_word_c  = '{plane_id: req_plane_id, req_type: req_type_t'(req_type)};
  assign push_land_c = req_valid && req_ready && req_type;
  assign push_take_c = req_valid && req_ready && !req_type;
  assign pop_land_c  = (state_q == LOCK) && (grant_type_q == LANDING);
  assign pop_take_c  = (state_q == LOCK) && (grant_type_q == TAKEOFF);

  assign done_acc_c  = done_valid && done_ready;
  assign done_ok_c   = owner_vld_q[done_runway_id] && (owner_id_q[done_runway_id] == done_plane_id);

  // Lowest-index free runway; landing wins unless a waiting takeoff has hit the streak limit
  assign any_free_c  = !(&runway_active);
  assign free_idx_c  = runway_active[0];
  assign pick_land_c = !land_empty_c &&
                       !(!take_empty_c && (streak_q == STREAK_W'(MAX_LAND_STREAK)));

  assign rw_lock         = rw_lock_q;
  assign rw_unlock       = rw_unlock_q;
  assign rw_plane_id     = rw_plane_q;
  assign rw_runway_id    = rw_runway_q;
  assign grant_valid     = rw_lock_q;
  assign grant_plane_id  = rw_plane_q;
  assign grant_runway_id = rw_runway_q;
  assign grant_type      = grant_type_q;
  assign err_bad_done    = err_bad_done_q;

  sched_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(REQ_W)) u_land_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_land_c),
    .wdata   (req_word_c),
    .pop     (pop_land_c),
    .rdata_c (land_head_c),
    .empty_c (land_empty_c),
    .full_c  (land_full_c)
  );

  sched_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(REQ_W)) u_take_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_take_c),
    .wdata   (req_word_c),
    .pop     (pop_take_c),
    .rdata_c (take_head_c),
    .empty_c (take_empty_c),
    .full_c  (take_full_c)
  );

  // Next state and next registered outputs; decisions taken in IDLE show up one cycle later
  always_comb begin
    state_d      = state_q;
    rw_lock_d    = 1'b0;
    rw_unlock_d  = 1'b0;
    rw_plane_d   = rw_plane_q;
    rw_runway_d  = rw_runway_q;
    grant_type_d = grant_type_q;
    case (state_q)
      IDLE: begin
        if (done_full_q) begin
          state_d     = UNLOCK;
          rw_unlock_d = 1'b1;
          rw_plane_d  = done_plane_q;
          rw_runway_d = done_runway_q;
        end else if (any_free_c && (!land_empty_c || !take_empty_c)) begin
          state_d      = LOCK;
          rw_lock_d    = 1'b1;
          rw_runway_d  = free_idx_c;
          rw_plane_d   = pick_land_c ? land_head_c.plane_id : take_head_c.plane_id;
          grant_type_d = pick_land_c ? land_head_c.req_type : take_head_c.req_type;
        end
      end
      UNLOCK:  state_d = SETTLE;
      LOCK:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done holding register, owner table and landing streak bookkeeping
  always_comb begin
    done_full_d    = done_full_q;
    done_plane_d   = done_plane_q;
    done_runway_d  = done_runway_q;
    err_bad_done_d = 1'b0;
    owner_vld_d    = owner_vld_q;
    owner_id_d     = owner_id_q;
    streak_d       = streak_q;

    if (state_q == UNLOCK) begin
      done_full_d              = 1'b0;
      owner_vld_d[rw_runway_q] = 1'b0;
    end
    if (state_q == LOCK) begin
      owner_vld_d[rw_runway_q] = 1'b1;
      owner_id_d[rw_runway_q]  = rw_plane_q;
    end

    if (done_acc_c) begin
      if (done_ok_c) begin
        done_full_d   = 1'b1;
        done_plane_d  = done_plane_id;
        done_runway_d = done_runway_id;
      end else begin
        err_bad_done_d = 1'b1;
      end
    end

    if (take_empty_c) begin
      streak_d = '0;
    end else if (state_q == LOCK) begin
      if (grant_type_q == TAKEOFF) begin
        streak_d = '0;
      end else if (streak_q < STREAK_W'(MAX_LAND_STREAK)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rw_lock_q      <= 1'b0;
      rw_unlock_q    <= 1'b0;
      rw_plane_q     <= '0;
      rw_runway_q    <= 1'b0;
      grant_type_q   <= TAKEOFF;
      err_bad_done_q <= 1'b0;
      done_full_q    <= 1'b0;
      done_plane_q   <= '0;
      done_runway_q  <= 1'b0;
      owner_vld_q    <= '0;
      owner_id_q     <= '{default: '0};
      streak_q       <= '0;
    end else begin
      state_q        <= state_d;
      rw_lock_q      <= rw_lock_d;
      rw_unlock_q    <= rw_unlock_d;
      rw_plane_q     <= rw_plane_d;
      rw_runway_q    <= rw_runway_d;
      grant_type_q   <= grant_type_d;
      err_bad_done_q <= err_bad_done_d;
      done_full_q    <= done_full_d;
      done_plane_q   <= done_plane_d;
      done_runway_q  <= done_runway_d;
      owner_vld_q    <= owner_vld_d;
      owner_id_q     <= owner_id_d;
      streak_q       <= streak_d;
    end
  end

endmodule

// File: tb/tb_runway_scheduler.sv
// Self-checking bench for runway_scheduler: directed scenarios plus randomized batches
// checked against a queue-level model of the grant policy.
module tb_runway_scheduler;

  localparam int MAXS = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_type;
  logic [3:0] req_plane_id;
  logic       done_valid, done_ready, done_runway_id;
  logic [3:0] done_plane_id;
  logic [1:0] runway_active;
  logic       rw_lock, rw_unlock, rw_runway_id;
  logic [3:0] rw_plane_id;
  logic       grant_valid, grant_runway_id, grant_type, err_bad_done;
  logic [3:0] grant_plane_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int         cyc = 0;
  int         n_lock = 0, n_unlock = 0, n_err = 0, n_overlap = 0, n_alias_bad = 0;
  int         last_lock_cyc = 0, last_unlock_cyc = 0;
  logic [3:0] g_plane[$];
  logic       g_type[$];
  logic       g_rw[$];

  runway_scheduler dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_plane_id    (req_plane_id),
    .req_type        (req_type),
    .done_valid      (done_valid),
    .done_ready      (done_ready),
    .done_plane_id   (done_plane_id),
    .done_runway_id  (done_runway_id),
    .runway_active   (runway_active),
    .rw_lock         (rw_lock),
    .rw_unlock       (rw_unlock),
    .rw_plane_id     (rw_plane_id),
    .rw_runway_id    (rw_runway_id),
    .grant_valid     (grant_valid),
    .grant_plane_id  (grant_plane_id),
    .grant_runway_id (grant_runway_id),
    .grant_type      (grant_type),
    .err_bad_done    (err_bad_done)
  );

  always #5 clock = ~clock;

  // Output monitor, sampling on the falling edge
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (grant_valid) begin
      g_plane.push_back(grant_plane_id);
      g_type.push_back(grant_type);
      g_rw.push_back(grant_runway_id);
    end
    if (rw_lock) begin
      n_lock <= n_lock + 1;
      last_lock_cyc <= cyc + 1;
    end
    if (rw_unlock) begin
      n_unlock <= n_unlock + 1;
      last_unlock_cyc <= cyc + 1;
    end
    if (rw_lock && rw_unlock) n_overlap <= n_overlap + 1;
    if (err_bad_done) n_err <= n_err + 1;
    if (grant_valid && (!rw_lock || grant_plane_id !== rw_plane_id ||
                        grant_runway_id !== rw_runway_id)) n_alias_bad <= n_alias_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_type = 1'b0; req_plane_id = '0;
    done_valid = 1'b0; done_plane_id = '0; done_runway_id = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    runway_active = 2'b00;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_req(input logic t, input logic [3:0] id);
    req_valid = 1'b1; req_type = t; req_plane_id = id;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_grants(input int target, input int budget, output bit ok);
    int k = 0;
    while (g_plane.size() < target && k < budget) begin
      tick();
      k++;
    end
    ok = (g_plane.size() >= target);
  endtask

  task automatic test_reset();
    int l0, u0, e0;
    idle_inputs();
    runway_active = 2'b00;
    reset_n = 1'b0;
    tick(); tick();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_t0: got %0b exp 1", req_ready); end
    req_type = 1'b1; #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_t1: got %0b exp 1", req_ready); end
    req_type = 1'b0;
    n_tests++; if (done_ready !== 1'b1) begin n_fail++; $display("FAIL reset_done_ready: got %0b exp 1", done_ready); end
    n_tests++;
    if ({rw_lock, rw_unlock, grant_valid, err_bad_done, grant_type, rw_runway_id, grant_runway_id} !== 7'b0 ||
        rw_plane_id !== 4'd0 || grant_plane_id !== 4'd0) begin
      n_fail++; $display("FAIL reset_outputs: lock=%0b unlock=%0b gv=%0b err=%0b plane=%0h exp all 0",
                         rw_lock, rw_unlock, grant_valid, err_bad_done, rw_plane_id);
    end
    reset_n = 1'b1;
    l0 = n_lock; u0 = n_unlock; e0 = n_err;
    repeat (20) tick();
    n_tests++;
    if (n_lock != l0 || n_unlock != u0 || n_err != e0) begin
      n_fail++; $display("FAIL idle_no_pulses: lock=%0d unlock=%0d err=%0d exp 0", n_lock-l0, n_unlock-u0, n_err-e0);
    end
    n_tests++; if (req_ready !== 1'b1 || done_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: req=%0b done=%0b exp 1 1", req_ready, done_ready); end
  endtask

  task automatic test_latency();
    bit ok;
    int base;
    do_reset();
    req_valid = 1'b1; req_type = 1'b1; req_plane_id = 4'd5;
    tick();
    req_valid = 1'b0;
    n_tests++; if (rw_lock !== 1'b0) begin n_fail++; $display("FAIL lat_early_lock: got %0b exp 0 at N+1", rw_lock); end
    tick();
    n_tests++;
    if (rw_lock !== 1'b1 || grant_valid !== 1'b1 || grant_plane_id !== 4'd5 ||
        grant_runway_id !== 1'b0 || grant_type !== 1'b1) begin
      n_fail++; $display("FAIL lat_grant: lock=%0b gv=%0b plane=%0d rw=%0b type=%0b exp 1 1 5 0 1",
                         rw_lock, grant_valid, grant_plane_id, grant_runway_id, grant_type);
    end
    runway_active = 2'b01;
    base = g_plane.size();
    push_req(1'b1, 4'd6);
    wait_grants(base + 1, 20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL second_grant_timeout: got none exp 1 grant"); end
    else if (g_rw[base] !== 1'b1 || g_plane[base] !== 4'd6) begin
      n_fail++; $display("FAIL second_grant_runway: rw=%0b plane=%0d exp 1 6", g_rw[base], g_plane[base]);
    end
    runway_active = 2'b11;
    repeat (3) tick();
  endtask

  task automatic test_fifo_full();
    int l0;
    do_reset();
    runway_active = 2'b11;
    l0 = n_lock;
    for (int i = 0; i < 4; i++) push_req(1'b1, 4'(i + 1));
    req_type = 1'b1; #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_land_ready: got %0b exp 0", req_ready); end
    req_type = 1'b0; #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_take_ready: got %0b exp 1", req_ready); end
    repeat (5) tick();
    n_tests++; if (n_lock != l0) begin n_fail++; $display("FAIL busy_no_grant: got %0d grants exp 0", n_lock - l0); end
  endtask

  task automatic test_starvation();
    bit ok;
    int base;
    logic [3:0] exp_p[6];
    logic       exp_t[6];
    exp_p = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd4, 4'd6};
    exp_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    runway_active = 2'b11;
    for (int i = 0; i < 4; i++) push_req(1'b1, 4'(i + 1));
    push_req(1'b0, 4'd9);
    base = g_plane.size();
    runway_active = 2'b10;
    wait_grants(base + 1, 20, ok);
    tick();
    push_req(1'b1, 4'd6);
    wait_grants(base + 6, 80, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL starve_timeout: got %0d grants exp 6", g_plane.size() - base); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (g_plane[base+i] !== exp_p[i] || g_type[base+i] !== exp_t[i] || g_rw[base+i] !== 1'b0) begin
          n_fail++; $display("FAIL starve_order[%0d]: plane=%0d type=%0b rw=%0b exp %0d %0b 0",
                             i, g_plane[base+i], g_type[base+i], g_rw[base+i], exp_p[i], exp_t[i]);
        end
      end
    end
    runway_active = 2'b11;
  endtask

  task automatic lock_plane5_rw0();
    bit ok;
    int base;
    base = g_plane.size();
    push_req(1'b1, 4'd5);
    wait_grants(base + 1, 20, ok);
    n_tests++; if (!ok || g_plane[base] !== 4'd5 || g_rw[base] !== 1'b0) begin n_fail++; $display("FAIL setup_lock5: ok=%0b exp plane 5 runway 0", ok); end
  endtask

  task automatic test_bad_done();
    int u0;
    do_reset();
    lock_plane5_rw0();
    runway_active = 2'b11;
    repeat (3) tick();
    u0 = n_unlock;
    done_valid = 1'b1; done_plane_id = 4'd3; done_runway_id = 1'b0;
    tick();
    done_valid = 1'b0;
    n_tests++; if (err_bad_done !== 1'b1 || done_ready !== 1'b1) begin n_fail++; $display("FAIL bad_done_err: err=%0b done_ready=%0b exp 1 1", err_bad_done, done_ready); end
    tick();
    n_tests++; if (err_bad_done !== 1'b0) begin n_fail++; $display("FAIL bad_done_pulse_len: got %0b exp 0", err_bad_done); end
    repeat (8) tick();
    n_tests++; if (n_unlock != u0) begin n_fail++; $display("FAIL bad_done_unlock: got %0d unlocks exp 0", n_unlock - u0); end
    done_valid = 1'b1; done_plane_id = 4'd5; done_runway_id = 1'b0;
    tick();
    done_valid = 1'b0;
    n_tests++; if (done_ready !== 1'b0 || rw_unlock !== 1'b0) begin n_fail++; $display("FAIL good_done_n1: done_ready=%0b unlock=%0b exp 0 0", done_ready, rw_unlock); end
    tick();
    n_tests++;
    if (rw_unlock !== 1'b1 || rw_lock !== 1'b0 || rw_plane_id !== 4'd5 || rw_runway_id !== 1'b0 || err_bad_done !== 1'b0) begin
      n_fail++; $display("FAIL good_done_unlock: unlock=%0b lock=%0b plane=%0d rw=%0b err=%0b exp 1 0 5 0 0",
                         rw_unlock, rw_lock, rw_plane_id, rw_runway_id, err_bad_done);
    end
    repeat (3) tick();
    done_valid = 1'b1; done_plane_id = 4'd5; done_runway_id = 1'b0;
    tick();
    done_valid = 1'b0;
    n_tests++; if (err_bad_done !== 1'b1) begin n_fail++; $display("FAIL stale_done_err: got %0b exp 1", err_bad_done); end
    tick();
  endtask

  task automatic test_unlock_first();
    bit ok;
    int base, acc_cyc, u0;
    do_reset();
    lock_plane5_rw0();
    runway_active = 2'b01;
    repeat (3) tick();
    base = g_plane.size();
    u0 = n_unlock;
    req_valid = 1'b1; req_type = 1'b1; req_plane_id = 4'd7;
    done_valid = 1'b1; done_plane_id = 4'd5; done_runway_id = 1'b0;
    tick();
    idle_inputs();
    acc_cyc = cyc;
    wait_grants(base + 1, 20, ok);
    n_tests++;
    if (!ok || n_unlock != u0 + 1) begin n_fail++; $display("FAIL both_timeout: grant_ok=%0b unlocks=%0d exp 1 1", ok, n_unlock - u0); end
    else begin
      n_tests++;
      if (last_unlock_cyc != acc_cyc + 1 || last_lock_cyc != acc_cyc + 4) begin
        n_fail++; $display("FAIL unlock_then_lock: unlock@+%0d lock@+%0d exp +1 +4",
                           last_unlock_cyc - acc_cyc, last_lock_cyc - acc_cyc);
      end
      n_tests++; if (g_plane[base] !== 4'd7 || g_rw[base] !== 1'b1) begin n_fail++; $display("FAIL both_grant: plane=%0d rw=%0b exp 7 1", g_plane[base], g_rw[base]); end
    end
    runway_active = 2'b11;
    tick();
  endtask

  task automatic test_reset_midop();
    int l0;
    do_reset();
    l0 = n_lock;
    push_req(1'b1, 4'd4);
    reset_n = 1'b0;
    tick();
    n_tests++; if (rw_lock !== 1'b0 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset_pulse: lock=%0b gv=%0b exp 0 0", rw_lock, grant_valid); end
    reset_n = 1'b1;
    repeat (8) tick();
    n_tests++; if (n_lock != l0) begin n_fail++; $display("FAIL midop_reset_aborted: got %0d grants exp 0", n_lock - l0); end
  endtask

  task automatic test_random();
    bit         ok;
    int         nl, nt, base, streak, fr;
    logic [3:0] lq[$], tq[$], exp_p[$];
    logic       exp_t[$];
    logic [3:0] id;
    logic       t;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      runway_active = 2'b11;
      nl = $urandom_range(0, 4);
      nt = $urandom_range(0, 4);
      if (nl + nt == 0) nl = 1;
      lq.delete(); tq.delete(); exp_p.delete(); exp_t.delete();
      while (nl + nt > 0) begin
        if (nl == 0) t = 1'b0;
        else if (nt == 0) t = 1'b1;
        else t = 1'($urandom_range(0, 1));
        id = 4'($urandom_range(0, 15));
        req_type = t; #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready it%0d: got %0b exp 1", it, req_ready); end
        push_req(t, id);
        if (t) begin lq.push_back(id); nl--; end
        else begin tq.push_back(id); nt--; end
      end
      // Grant policy: landing first, takeoff once MAXS landings have passed a waiting takeoff
      streak = 0;
      while (lq.size() + tq.size() > 0) begin
        if (lq.size() > 0 && !(tq.size() > 0 && streak == MAXS)) begin
          exp_p.push_back(lq.pop_front()); exp_t.push_back(1'b1);
          streak = (tq.size() > 0) ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else begin
          exp_p.push_back(tq.pop_front()); exp_t.push_back(1'b0);
          streak = 0;
        end
      end
      base = g_plane.size();
      fr = $urandom_range(0, 1);
      runway_active = (fr == 0) ? 2'b10 : 2'b01;
      wait_grants(base + exp_p.size(), 100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rnd_timeout it%0d: got %0d grants exp %0d", it, g_plane.size() - base, exp_p.size()); end
      else begin
        for (int i = 0; i < exp_p.size(); i++) begin
          n_tests++;
          if (g_plane[base+i] !== exp_p[i] || g_type[base+i] !== exp_t[i] || g_rw[base+i] !== 1'(fr)) begin
            n_fail++; $display("FAIL rnd_grant it%0d[%0d]: plane=%0d type=%0b rw=%0b exp %0d %0b %0d",
                               it, i, g_plane[base+i], g_type[base+i], g_rw[base+i], exp_p[i], exp_t[i], fr);
          end
        end
      end
      runway_active = 2'b11;
      repeat (3) tick();
    end
  endtask

  initial begin
    idle_inputs();
    runway_active = 2'b00;
    reset_n = 1'b0;
    test_reset();
    test_latency();
    test_fifo_full();
    test_starvation();
    test_bad_done();
    test_unlock_first();
    test_reset_midop();
    test_random();
    n_tests++; if (n_overlap != 0) begin n_fail++; $display("FAIL lock_unlock_overlap: got %0d cycles exp 0", n_overlap); end
    n_tests++; if (n_alias_bad != 0) begin n_fail++; $display("FAIL grant_alias: got %0d cycles exp 0", n_alias_bad); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
